// File: rtl/random_bcd_display.sv
// random_bcd_display: double-dabble BCD converter driving four seven-segment digits; RANDOM_BCD_DISPLAY_LZB_EN enables leading-zero blanking
module random_bcd_display #(
  parameter int WIDTH = 13
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_freeze,
  output logic [15:0]      o_bcd,
  output logic [6:0]       o_hex0,
  output logic [6:0]       o_hex1,
  output logic [6:0]       o_hex2,
  output logic [6:0]       o_hex3,
  output logic             o_busy,
  output logic             o_done
);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`ifdef RANDOM_BCD_DISPLAY_LZB_EN
  localparam logic [6:0] LEAD = 7'h7F;
`else
  localparam logic [6:0] LEAD = 7'h40;
`endif
  state_t           state;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] sr;
  logic [15:0]      scr;
  logic [15:0]      adj;
  logic [3:0]       cnt;
  logic             z3;
  logic             z2;
  logic             z1;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? 4'(n + 4'd3) : n;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_comb begin
    adj = {add3(scr[15:12]), add3(scr[11:8]), add3(scr[7:4]), add3(scr[3:0])};
`ifdef RANDOM_BCD_DISPLAY_LZB_EN
    z3 = scr[15:12] == 4'd0;
    z2 = z3 && (scr[11:8] == 4'd0);
    z1 = z2 && (scr[7:4] == 4'd0);
`else
    z3 = 1'b0;
    z2 = 1'b0;
    z1 = 1'b0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      cap    <= '0;
      sr     <= '0;
      scr    <= '0;
      cnt    <= '0;
      o_bcd  <= '0;
      o_hex0 <= 7'h40;
      o_hex1 <= LEAD;
      o_hex2 <= LEAD;
      o_hex3 <= LEAD;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!i_freeze && i_value != cap) begin
            cap    <= i_value;
            sr     <= i_value;
            scr    <= '0;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {scr, sr} <= {adj, sr} << 1;
          cnt       <= cnt + 4'd1;
          if (cnt == 4'(WIDTH - 1)) state <= S_DONE;
        end
        S_DONE: begin
          o_bcd  <= scr;
          o_hex0 <= seg(scr[3:0]);
          o_hex1 <= z1 ? 7'h7F : seg(scr[7:4]);
          o_hex2 <= z2 ? 7'h7F : seg(scr[11:8]);
          o_hex3 <= z3 ? 7'h7F : seg(scr[15:12]);
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_random_bcd_display.sv
// tb_random_bcd_display: scoreboard bench for random_bcd_display with directed vectors
module tb_random_bcd_display;
  typedef struct {
    logic [15:0] bcd;
    logic [27:0] hex;
    int          cyc;
  } exp_t;
`ifdef RANDOM_BCD_DISPLAY_LZB_EN
  localparam logic [6:0] Z = 7'h7F;
`else
  localparam logic [6:0] Z = 7'h40;
`endif
  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [12:0] i_value = '0;
  logic        i_freeze = 1'b0;
  logic [15:0] o_bcd;
  logic [6:0]  o_hex0;
  logic [6:0]  o_hex1;
  logic [6:0]  o_hex2;
  logic [6:0]  o_hex3;
  logic        o_busy;
  logic        o_done;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          k;
  exp_t        q[$];
  exp_t        e;

  random_bcd_display #(.WIDTH(13)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_value(i_value), .i_freeze(i_freeze),
    .o_bcd(o_bcd), .o_hex0(o_hex0), .o_hex1(o_hex1), .o_hex2(o_hex2),
    .o_hex3(o_hex3), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [15:0] b, input logic [27:0] h, input int c);
    q.push_back('{bcd: b, hex: h, cyc: c});
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      chk("done_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic conv(input logic [12:0] v, input logic [15:0] b, input logic [27:0] h);
    @(negedge clk);
    i_value = v;
    push(b, h, cyc + 15);
    @(negedge clk);
    chk("busy_start", 32'(o_busy), 32'd1);
    drain();
  endtask

  initial forever begin
    @(negedge clk);
    if (o_done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(o_bcd), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("bcd", 32'(o_bcd), 32'(e.bcd));
        chk("hex", 32'({o_hex3, o_hex2, o_hex1, o_hex0}), 32'(e.hex));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_bcd", 32'(o_bcd), 32'h0);
    chk("rst_hex", 32'({o_hex3, o_hex2, o_hex1, o_hex0}), 32'({Z, Z, Z, 7'h40}));
    chk("rst_busy", 32'(o_busy), 32'd0);
    repeat (50) @(negedge clk);
    chk("idle_busy", 32'(o_busy), 32'd0);
    conv(13'd1234, 16'h1234, {7'h79, 7'h24, 7'h30, 7'h19});
    conv(13'd8191, 16'h8191, {7'h00, 7'h79, 7'h10, 7'h79});
    conv(13'd7, 16'h0007, {Z, Z, Z, 7'h78});
    @(negedge clk);
    i_value = 13'd7;
    repeat (20) @(negedge clk);
    chk("same_value_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    i_value = 13'd500;
    k = cyc;
    push(16'h0500, {Z, 7'h12, 7'h40, 7'h40}, k + 15);
    repeat (3) @(negedge clk);
    i_value = 13'd42;
    push(16'h0042, {Z, Z, 7'h19, 7'h24}, k + 30);
    drain();
    conv(13'd9, 16'h0009, {Z, Z, Z, 7'h10});
    i_freeze = 1'b1;
    i_value = 13'd77;
    repeat (20) @(negedge clk);
    chk("freeze_busy", 32'(o_busy), 32'd0);
    chk("freeze_bcd", 32'(o_bcd), 32'h0009);
    i_freeze = 1'b0;
    push(16'h0077, {Z, Z, 7'h78, 7'h78}, cyc + 15);
    drain();
    i_value = 13'd999;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_bcd", 32'(o_bcd), 32'h0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_hex", 32'({o_hex3, o_hex2, o_hex1, o_hex0}), 32'({Z, Z, Z, 7'h40}));
    i_rst = 1'b0;
    push(16'h0999, {Z, 7'h10, 7'h10, 7'h10}, cyc + 15);
    @(negedge clk);
    chk("reconv_busy", 32'(o_busy), 32'd1);
    drain();
    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
